// File: rtl/dsp48_mult_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency multiplier among N_REQ requesters.
// A tag pipeline tracks every in-flight product so each result returns to the requester that issued it.
module dsp48_mult_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DIN1_WIDTH   = 16,
    parameter int unsigned DIN2_WIDTH   = 16,
    parameter int unsigned DOUT_WIDTH   = 32,
    parameter int unsigned MULT_LATENCY = 4,
    localparam int unsigned ID_W        = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [N_REQ*DIN1_WIDTH-1:0]   req_din1,
    input  logic [N_REQ*DIN2_WIDTH-1:0]   req_din2,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    output logic [DIN1_WIDTH-1:0]         mult_din1,
    output logic [DIN2_WIDTH-1:0]         mult_din2,
    output logic                          mult_din_valid,
    input  logic [DOUT_WIDTH-1:0]         mult_dout,
    input  logic                          mult_dout_valid,
    output logic [DOUT_WIDTH-1:0]         dout,
    output logic [N_REQ-1:0]              dout_valid,
    output logic [ID_W-1:0]               dout_id,
    output logic                          tag_err
);

    logic [ID_W-1:0]                   last_q, last_d;
    logic [ID_W-1:0]                   issue_id_q, issue_id_d;
    logic [DIN1_WIDTH-1:0]             mult_din1_q, mult_din1_d;
    logic [DIN2_WIDTH-1:0]             mult_din2_q, mult_din2_d;
    logic                              mult_din_valid_q, mult_din_valid_d;
    logic [MULT_LATENCY-1:0]           tag_vld_q, tag_vld_d;
    logic [MULT_LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;
    logic [DOUT_WIDTH-1:0]             dout_q, dout_d;
    logic [N_REQ-1:0]                  dout_valid_q, dout_valid_d;
    logic [ID_W-1:0]                   dout_id_q, dout_id_d;
    logic                              tag_err_q, tag_err_d;

    logic                              grant_c;
    logic [ID_W-1:0]                   grant_id_c;
    int unsigned                       best_dist_c;
    int unsigned                       dist_c;
    logic                              handshake_c;

    // Pick the valid requester closest (circularly) after the last granted index.
    always_comb begin
        grant_c     = 1'b0;
        grant_id_c  = '0;
        best_dist_c = N_REQ;
        dist_c      = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            dist_c = (i + N_REQ - 1 - 32'(last_q)) % N_REQ;
            if (en && req_valid[i] && (dist_c < best_dist_c)) begin
                grant_c     = 1'b1;
                grant_id_c  = ID_W'(i);
                best_dist_c = dist_c;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_c) begin
            req_ready[grant_id_c] = 1'b1;
        end
        handshake_c = |(req_valid & req_ready);
    end

    always_comb begin
        last_d           = last_q;
        issue_id_d       = '0;
        mult_din1_d      = '0;
        mult_din2_d      = '0;
        mult_din_valid_d = 1'b0;
        if (handshake_c) begin
            last_d           = grant_id_c;
            issue_id_d       = grant_id_c;
            mult_din1_d      = req_din1[32'(grant_id_c)*DIN1_WIDTH +: DIN1_WIDTH];
            mult_din2_d      = req_din2[32'(grant_id_c)*DIN2_WIDTH +: DIN2_WIDTH];
            mult_din_valid_d = 1'b1;
        end
    end

    // Tag shift register mirrors the multiplier pipeline; never stalls.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = mult_din_valid_q;
        tag_id_d[0]  = issue_id_q;
        for (int unsigned s = 1; s < MULT_LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_id_d    = dout_id_q;
        dout_valid_d = '0;
        tag_err_d    = tag_err_q | (mult_dout_valid != tag_vld_q[MULT_LATENCY-1]);
        if (mult_dout_valid && tag_vld_q[MULT_LATENCY-1]) begin
            dout_d                                 = mult_dout;
            dout_id_d                              = tag_id_q[MULT_LATENCY-1];
            dout_valid_d[tag_id_q[MULT_LATENCY-1]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q           <= ID_W'(N_REQ - 1);
            issue_id_q       <= '0;
            mult_din1_q      <= '0;
            mult_din2_q      <= '0;
            mult_din_valid_q <= 1'b0;
            tag_vld_q        <= '0;
            tag_id_q         <= '0;
            dout_q           <= '0;
            dout_valid_q     <= '0;
            dout_id_q        <= '0;
            tag_err_q        <= 1'b0;
        end else begin
            last_q           <= last_d;
            issue_id_q       <= issue_id_d;
            mult_din1_q      <= mult_din1_d;
            mult_din2_q      <= mult_din2_d;
            mult_din_valid_q <= mult_din_valid_d;
            tag_vld_q        <= tag_vld_d;
            tag_id_q         <= tag_id_d;
            dout_q           <= dout_d;
            dout_valid_q     <= dout_valid_d;
            dout_id_q        <= dout_id_d;
            tag_err_q        <= tag_err_d;
        end
    end

    assign mult_din1      = mult_din1_q;
    assign mult_din2      = mult_din2_q;
    assign mult_din_valid = mult_din_valid_q;
    assign dout           = dout_q;
    assign dout_valid     = dout_valid_q;
    assign dout_id        = dout_id_q;
    assign tag_err        = tag_err_q;

endmodule

// File: tb/tb_dsp48_mult_arbiter.sv
// Bench for dsp48_mult_arbiter: behavioural round-robin model plus a scoreboard of expected products,
// with a non-reset multiplier model whose latency can be changed to inject faults.
module tb_dsp48_mult_arbiter;

    localparam int N   = 4;
    localparam int W1  = 16;
    localparam int W2  = 16;
    localparam int WO  = 32;
    localparam int LAT = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N*W1-1:0] req_din1;
    logic [N*W2-1:0] req_din2;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [W1-1:0]   mult_din1;
    logic [W2-1:0]   mult_din2;
    logic            mult_din_valid;
    logic [WO-1:0]   mult_dout;
    logic            mult_dout_valid;
    logic [WO-1:0]   dout;
    logic [N-1:0]    dout_valid;
    logic [IDW-1:0]  dout_id;
    logic            tag_err;

    dsp48_mult_arbiter #(
        .N_REQ(N), .DIN1_WIDTH(W1), .DIN2_WIDTH(W2), .DOUT_WIDTH(WO), .MULT_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_din1(req_din1), .req_din2(req_din2), .req_valid(req_valid), .req_ready(req_ready),
        .mult_din1(mult_din1), .mult_din2(mult_din2), .mult_din_valid(mult_din_valid),
        .mult_dout(mult_dout), .mult_dout_valid(mult_dout_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_id(dout_id), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Multiplier model: not reset, latency selectable at run time.
    int                   mult_lat = LAT;
    logic                 pv [0:7];
    logic signed [WO-1:0] pp [0:7];
    initial for (int s = 0; s < 8; s++) begin pv[s] = 1'b0; pp[s] = '0; end
    always @(posedge clk) begin
        for (int s = 7; s > 0; s--) begin
            pv[s] <= pv[s-1];
            pp[s] <= pp[s-1];
        end
        pv[0] <= mult_din_valid;
        pp[0] <= $signed(mult_din1) * $signed(mult_din2);
    end
    assign mult_dout_valid = pv[mult_lat-1];
    assign mult_dout       = pp[mult_lat-1];

    typedef struct {
        int            id;
        logic [WO-1:0] val;
        int            due;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    int            rr_last    = N - 1;
    logic          prev_hs    = 1'b0;
    logic [W1-1:0] prev_d1    = '0;
    logic [W2-1:0] prev_d2    = '0;
    logic [WO-1:0] hold_dout  = '0;
    int            hold_id    = 0;
    logic          fault_mode = 1'b0;
    logic          mon_on     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input logic e);
        int idx;
        if (!e) return -1;
        for (int k = 1; k <= N; k++) begin
            idx = (rr_last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] v, input logic e,
                        input logic [N*W1-1:0] d1, input logic [N*W2-1:0] d2);
        int                   g;
        logic [N-1:0]         exp_ready;
        logic signed [W1-1:0] a;
        logic signed [W2-1:0] b;
        logic signed [WO-1:0] p;
        exp_t                 item;
        @(negedge clk);
        req_valid = v;
        en        = e;
        req_din1  = d1;
        req_din2  = d2;
        #1;
        chk("mult_din_valid", 64'(mult_din_valid), 64'(prev_hs));
        chk("mult_din1", 64'(mult_din1), prev_hs ? 64'(prev_d1) : 64'd0);
        chk("mult_din2", 64'(mult_din2), prev_hs ? 64'(prev_d2) : 64'd0);
        g = model_grant(v, e);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (g >= 0) begin
            a        = d1[g*W1 +: W1];
            b        = d2[g*W2 +: W2];
            p        = a * b;
            prev_d1  = a;
            prev_d2  = b;
            prev_hs  = 1'b1;
            rr_last  = g;
            item.id  = g;
            item.val = p;
            item.due = cyc + 6;
            if (!fault_mode) sb.push_back(item);
        end else begin
            prev_hs = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1, '0, '0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " mult_din_valid"}, 64'(mult_din_valid), 64'd0);
        chk({tag, " mult_din1"}, 64'(mult_din1), 64'd0);
        chk({tag, " mult_din2"}, 64'(mult_din2), 64'd0);
        chk({tag, " dout"}, 64'(dout), 64'd0);
        chk({tag, " dout_valid"}, 64'(dout_valid), 64'd0);
        chk({tag, " dout_id"}, 64'(dout_id), 64'd0);
        chk({tag, " tag_err"}, 64'(tag_err), 64'd0);
    endtask

    // Asynchronous reset asserted mid-cycle; in-flight products are forgotten by the model.
    task automatic assert_rst();
        @(negedge clk);
        #2;
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk_zero("rst");
        sb.delete();
        prev_hs   = 1'b0;
        rr_last   = N - 1;
        hold_dout = '0;
        hold_id   = 0;
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic quiesce_reset();
        idle(8);
        assert_rst();
    endtask

    // Monitor: every dout_valid must match the oldest outstanding expected product, on time.
    always @(negedge clk) begin
        exp_t         e;
        logic [N-1:0] oh;
        if (!rst && mon_on) begin
            if (dout_valid != '0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_dout_valid: got %0h expected 0 (cycle %0d)", dout_valid, cyc);
                end else begin
                    e  = sb.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    chk("dout", 64'(dout), 64'(e.val));
                    chk("dout_id", 64'(dout_id), 64'(e.id));
                    chk("dout_valid", 64'(dout_valid), 64'(oh));
                    chk("latency", 64'(cyc), 64'(e.due));
                    hold_dout = e.val;
                    hold_id   = e.id;
                end
            end else begin
                chk("dout_hold", 64'(dout), 64'(hold_dout));
                chk("dout_id_hold", 64'(dout_id), 64'(hold_id));
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    total++;
                    bad++;
                    $display("FAIL missing_result: got none expected id %0d due cycle %0d (cycle %0d)",
                             sb[0].id, sb[0].due, cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [N*W1-1:0] d1;
        logic [N*W2-1:0] d2;
        int              c0;
        rst       = 1'b1;
        en        = 1'b0;
        req_valid = '0;
        req_din1  = '0;
        req_din2  = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        #2;
        rst = 1'b0;
        mon_on = 1'b1;

        // Single request: 3 * -5.
        idle(1);
        d1 = '0; d1[W1-1:0] = 16'sd3;
        d2 = '0; d2[W2-1:0] = -16'sd5;
        step(4'b0001, 1'b1, d1, d2);
        idle(8);

        // All four continuously valid.
        quiesce_reset();
        for (int i = 0; i < N; i++) begin
            d1[i*W1 +: W1] = W1'(i + 1);
            d2[i*W2 +: W2] = W2'(10);
        end
        for (int i = 0; i < 12; i++) step(4'b1111, 1'b1, d1, d2);
        idle(8);
        chk("tag_err_stream", 64'(tag_err), 64'd0);

        // Requesters 1 and 3 only.
        quiesce_reset();
        for (int i = 0; i < 8; i++) step(4'b1010, 1'b1, d1, d2);
        idle(8);

        // en low for 3 cycles after the second grant.
        quiesce_reset();
        step(4'b1111, 1'b1, d1, d2);
        step(4'b1111, 1'b1, d1, d2);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, d1, d2);
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, d1, d2);
        idle(8);

        // Randomized traffic.
        quiesce_reset();
        for (int i = 0; i < 300; i++) begin
            for (int r = 0; r < N; r++) begin
                d1[r*W1 +: W1] = W1'($urandom);
                d2[r*W2 +: W2] = W2'($urandom);
            end
            step(N'($urandom), ($urandom_range(0, 7) != 0), d1, d2);
        end
        idle(8);
        chk("tag_err_random", 64'(tag_err), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Reset with three products in flight; the multiplier keeps its stale outputs.
        quiesce_reset();
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, d1, d2);
        idle(2);
        assert_rst();
        idle(4);
        chk("tag_err_stale", 64'(tag_err), 64'd1);
        step(4'b1110, 1'b1, d1, d2);
        idle(8);
        chk("tag_err_sticky", 64'(tag_err), 64'd1);

        // Multiplier one cycle slower than the tag pipeline.
        quiesce_reset();
        mult_lat   = 5;
        fault_mode = 1'b1;
        step(4'b0100, 1'b1, d1, d2);
        c0 = cyc;
        chk("tag_err_pre_fault", 64'(tag_err), 64'd0);
        for (int i = 0; i < 8; i++) begin
            step('0, 1'b1, '0, '0);
            chk("tag_err_fault", 64'(tag_err), (cyc >= c0 + 6) ? 64'd1 : 64'd0);
            chk("dout_valid_fault", 64'(dout_valid), 64'd0);
        end
        chk("sb_final", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
